// File: rtl/debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_if
//  Description : Level/event bundle between a debouncer and its polling
//                consumer. The debouncer takes the slave view; the consumer
//                (or a test driver) takes the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_mask;
    logic             event_valid;
    logic             event_ack;

    modport master (
        output in,
        output event_ack,
        input  out,
        input  rise,
        input  fall,
        input  event_mask,
        input  event_valid
    );

    modport slave (
        input  in,
        input  event_ack,
        output out,
        output rise,
        output fall,
        output event_mask,
        output event_valid
    );
endinterface
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer
//  Description : Per-bit debouncer for already-synchronized inputs. A new
//                level is accepted after STABLE_CYCLES consecutive samples
//                that differ from the current debounced level. Accepted
//                changes produce one-cycle rise/fall pulses and are collected
//                into a sticky event mask cleared by a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic        clock,
    input  logic        reset,
    debouncer_if.slave  bus
);

    // Counter only ever holds 0..STABLE_CYCLES-1; the accepting sample clears it.
    localparam int               c_CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [WIDTH-1:0]   r_mask;
    logic               r_valid;
    logic [c_CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_accept;
    logic [WIDTH-1:0]   w_ack_clear;
    logic [WIDTH-1:0]   w_mask_next;

    assign w_diff = bus.in ^ r_out;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            // This sample completes the run when the count already holds STABLE_CYCLES-1.
            assign w_accept[i] = w_diff[i] && (r_cnt[i] == c_LAST);

            // Per-bit stability counter: restarts whenever the input matches out or is accepted.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_cnt[i] <= '0;
                end else if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    endgenerate

    // An ack only clears what the consumer could see this cycle; new acceptances win.
    assign w_ack_clear = bus.event_ack ? r_mask : '0;
    assign w_mask_next = (r_mask & ~w_ack_clear) | w_accept;

    // Debounced level and its edge pulses, updated together on acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out  <= INIT_VALUE;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_out  <= r_out ^ w_accept;
            r_rise <= w_accept & bus.in;
            r_fall <= w_accept & ~bus.in;
        end
    end

    // Sticky change mask and its valid flag, registered from the same next value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_mask  <= w_mask_next;
            r_valid <= |w_mask_next;
        end
    end

    assign bus.out         = r_out;
    assign bus.rise        = r_rise;
    assign bus.fall        = r_fall;
    assign bus.event_mask  = r_mask;
    assign bus.event_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer
//  Description : Self-checking bench for debouncer. Three instances:
//                A (WIDTH=2, STABLE_CYCLES=4, INIT=2'b10),
//                B (WIDTH=4, STABLE_CYCLES=1, INIT=0),
//                C (WIDTH=1, STABLE_CYCLES=4, INIT=0).
//                Each scenario pushes the expected per-cycle outputs into a
//                scoreboard queue as it drives stimulus and pops them when
//                the DUT outputs settle after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] mask;
        logic       valid;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int tests_run = 0;
    int failed    = 0;

    exp_t exp_q [$];

    debouncer_if #(.WIDTH(2)) ifa ();
    debouncer_if #(.WIDTH(4)) ifb ();
    debouncer_if #(.WIDTH(1)) ifc ();

    debouncer #(.WIDTH(2), .STABLE_CYCLES(4), .INIT_VALUE(2'b10)) ua (
        .clock (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    debouncer #(.WIDTH(4), .STABLE_CYCLES(1), .INIT_VALUE(4'h0)) ub (
        .clock (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    debouncer #(.WIDTH(1), .STABLE_CYCLES(4), .INIT_VALUE(1'b0)) uc (
        .clock (clk),
        .reset (rst_c),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] o, input logic [3:0] r,
                                input logic [3:0] f, input logic [3:0] m,
                                input logic v);
        exp_t e;
        e.out = o; e.rise = r; e.fall = f; e.mask = m; e.valid = v;
        return e;
    endfunction

    function automatic exp_t obs_a();
        return mk({2'b00, ifa.out}, {2'b00, ifa.rise}, {2'b00, ifa.fall},
                  {2'b00, ifa.event_mask}, ifa.event_valid);
    endfunction

    function automatic exp_t obs_b();
        return mk(ifb.out, ifb.rise, ifb.fall, ifb.event_mask, ifb.event_valid);
    endfunction

    function automatic exp_t obs_c();
        return mk({3'b000, ifc.out}, {3'b000, ifc.rise}, {3'b000, ifc.fall},
                  {3'b000, ifc.event_mask}, ifc.event_valid);
    endfunction

    // Reset/init: in differs from INIT during reset; both bits change after 4 samples.
    task automatic test_reset();
        exp_t e, o;
        logic       tack [6];
        exp_t       texp [6];
        tack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        texp = '{mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h2,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h1,4'h1,4'h2,4'h3,1'b1),
                 mk(4'h1,4'h0,4'h0,4'h3,1'b1), mk(4'h1,4'h0,4'h0,4'h0,1'b0)};
        ifa.in = 2'b01;
        ifa.event_ack = 1'b0;
        // still in reset
        exp_q.push_back(mk(4'h2,4'h0,4'h0,4'h0,1'b0));
        @(negedge clk); #1;
        e = exp_q.pop_front(); o = obs_a();
        tests_run++;
        if (o !== e) begin
            failed++;
            $display("FAIL reset_held: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                     o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
        end
        // at release, before any edge
        @(negedge clk);
        rst_a = 1'b1;
        exp_q.push_back(mk(4'h2,4'h0,4'h0,4'h0,1'b0));
        #1;
        e = exp_q.pop_front(); o = obs_a();
        tests_run++;
        if (o !== e) begin
            failed++;
            $display("FAIL reset_release: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                     o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
        end
        for (int i = 0; i < 6; i++) begin
            ifa.event_ack = tack[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_a();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL reset_seq[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
        ifa.event_ack = 1'b0;
    endtask

    // Threshold: 3-sample pulse rejected, 4-sample pulse accepted.
    task automatic test_threshold();
        exp_t e, o;
        logic tin  [10];
        exp_t texp [10];
        tin  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        texp = '{mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h1,4'h1,4'h0,4'h1,1'b1), mk(4'h1,4'h0,4'h0,4'h1,1'b1)};
        ifc.event_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifc.in = tin[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_c();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL threshold[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
    endtask

    // Bounce: 1,0,1,1,0,1,1,1,1 yields a single rise after the final four 1s.
    task automatic test_bounce();
        exp_t e, o;
        logic tin  [10];
        exp_t texp [10];
        tin  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        texp = '{mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h0,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h1,4'h1,4'h0,4'h1,1'b1), mk(4'h1,4'h0,4'h0,4'h1,1'b1)};
        // return instance C to its reset state first
        ifc.in = 1'b0;
        rst_c = 1'b0;
        exp_q.push_back(mk(4'h0,4'h0,4'h0,4'h0,1'b0));
        #1;
        e = exp_q.pop_front(); o = obs_c();
        tests_run++;
        if (o !== e) begin
            failed++;
            $display("FAIL bounce_reset: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                     o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
        end
        #2;
        rst_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifc.in = tin[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_c();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL bounce[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
    endtask

    // Handshake race: bit1 accepted on the ack edge that clears pending bit0.
    task automatic test_handshake();
        exp_t e, o;
        logic [1:0] tin  [11];
        logic       tack [11];
        exp_t       texp [11];
        tin  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        tack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        texp = '{mk(4'h1,4'h0,4'h0,4'h0,1'b0), mk(4'h1,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h1,4'h0,4'h0,4'h0,1'b0), mk(4'h0,4'h0,4'h1,4'h1,1'b1),
                 mk(4'h0,4'h0,4'h0,4'h1,1'b1), mk(4'h0,4'h0,4'h0,4'h1,1'b1),
                 mk(4'h0,4'h0,4'h0,4'h1,1'b1), mk(4'h2,4'h2,4'h0,4'h2,1'b1),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h2,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0)};
        for (int i = 0; i < 11; i++) begin
            ifa.in = tin[i];
            ifa.event_ack = tack[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_a();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL handshake[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
        ifa.event_ack = 1'b0;
    endtask

    // Mid-operation reset at count 3/4; the change then needs 4 fresh samples.
    task automatic test_mid_reset();
        exp_t e, o;
        logic [1:0] tin  [13];
        exp_t       texp [13];
        tin  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01,
                 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        texp = '{mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h2,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h3,4'h1,4'h0,4'h1,1'b1),
                 mk(4'h3,4'h0,4'h0,4'h1,1'b1), mk(4'h3,4'h0,4'h0,4'h1,1'b1),
                 mk(4'h3,4'h0,4'h0,4'h1,1'b1), mk(4'h3,4'h0,4'h0,4'h1,1'b1),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h2,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h2,4'h0,4'h0,4'h0,1'b0), mk(4'h1,4'h1,4'h2,4'h3,1'b1),
                 mk(4'h1,4'h0,4'h0,4'h3,1'b1)};
        ifa.event_ack = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 8) begin
                rst_a = 1'b0;
                exp_q.push_back(mk(4'h2,4'h0,4'h0,4'h0,1'b0));
                #1;
                e = exp_q.pop_front(); o = obs_a();
                tests_run++;
                if (o !== e) begin
                    failed++;
                    $display("FAIL mid_reset_async: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                             o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
                end
                #2;
                rst_a = 1'b1;
            end
            ifa.in = tin[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_a();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL mid_reset[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
    endtask

    // Multi-bit with STABLE_CYCLES=1: every change passes after one register delay.
    task automatic test_multibit();
        exp_t e, o;
        logic [3:0] tin  [5];
        logic       tack [5];
        exp_t       texp [5];
        tin  = '{4'hA, 4'h5, 4'h5, 4'h5, 4'h5};
        tack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        texp = '{mk(4'hA,4'hA,4'h0,4'hA,1'b1), mk(4'h5,4'h5,4'hA,4'hF,1'b1),
                 mk(4'h5,4'h0,4'h0,4'hF,1'b1), mk(4'h5,4'h0,4'h0,4'h0,1'b0),
                 mk(4'h5,4'h0,4'h0,4'h0,1'b0)};
        for (int i = 0; i < 5; i++) begin
            ifb.in = tin[i];
            ifb.event_ack = tack[i];
            exp_q.push_back(texp[i]);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); o = obs_b();
            tests_run++;
            if (o !== e) begin
                failed++;
                $display("FAIL multibit[%0d]: got out=%h rise=%h fall=%h mask=%h valid=%b, expected out=%h rise=%h fall=%h mask=%h valid=%b",
                         i, o.out, o.rise, o.fall, o.mask, o.valid, e.out, e.rise, e.fall, e.mask, e.valid);
            end
        end
        ifb.event_ack = 1'b0;
    endtask

    initial begin
        ifa.in = 2'b01;  ifa.event_ack = 1'b0;
        ifb.in = 4'h0;   ifb.event_ack = 1'b0;
        ifc.in = 1'b0;   ifc.event_ack = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        rst_c = 1'b1;
        test_reset();
        test_threshold();
        test_bounce();
        test_handshake();
        test_mid_reset();
        test_multibit();
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/debouncer.md
# debouncer

Per-bit debouncer and change-event collector that sits directly downstream of the input synchronizer. It consumes already-synchronized switch/button/strap bits and accepts a new level only after it has been sampled unchanged for a programmable number of cycles. It emits one-cycle rise/fall pulses and a sticky change mask with a valid/ack handshake for a polling consumer.

## Interface
- WIDTH, 1: number of independent input bits.
- STABLE_CYCLES, 16: consecutive differing samples required to accept a new level; legal range ≥1.
- INIT_VALUE, 0 (WIDTH bits): debounced level loaded at reset.
- clock  input  1  rising-edge clock, same domain as the synchronizer output.
- reset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  synchronized raw levels.
- out  output  WIDTH  debounced levels.
- rise  output  WIDTH  one-cycle pulse per bit when out goes 0→1.
- fall  output  WIDTH  one-cycle pulse per bit when out goes 1→0.
- event_valid  output  1  high while any bit of event_mask is set.
- event_mask  output  WIDTH  sticky set of bits whose debounced level changed since the last ack.
- event_ack  input  1  consumer acknowledge; meaningful only when event_valid is high.

## Operation
- One counter per bit, width clog2(STABLE_CYCLES+1), saturating; all bits are fully independent.
- Each edge, per bit: if in == out, clear the counter. Otherwise increment it.
- When the increment would reach STABLE_CYCLES, the bit is accepted: out <= in, the counter clears, and rise or fall pulses for exactly one cycle. No further increment is applied.
- A bit that returns to out before acceptance restarts from zero. Partial counts never carry over.
- rise and fall are registered. They are never both high for the same bit, and they are low on every cycle without an acceptance.
- event_mask update each edge: next = (event_mask & ~(event_ack ? event_mask : 0)) | accepted_bits.
  - An ack clears only the bits visible in that cycle.
  - A bit accepted on the ack cycle stays set.
- event_valid = |event_mask, registered consistently with event_mask (same edge).
- event_ack while event_valid is low has no effect.
- Asserting reset (low) asynchronously sets out = INIT_VALUE, all counters = 0, rise = fall = 0, event_mask = 0, event_valid = 0. This holds mid-count or mid-handshake.
- Operation resumes on the first edge after reset deasserts. Reset release itself produces no pulse or event, even if in ≠ INIT_VALUE.

## Timing
- Latency: a level change on in that first appears at sampling edge E (held steady) updates out at edge E+STABLE_CYCLES−1. rise/fall pulse in the cycle after that same edge. The event_mask bit is set at that same edge.
- STABLE_CYCLES = 1: out follows in with one register delay. Every change produces a pulse.
- A glitch lasting N < STABLE_CYCLES samples produces no change on out, rise, fall or event_mask.
- A change held for exactly STABLE_CYCLES samples is accepted.
- Toggling continuously faster than STABLE_CYCLES never changes out.
- Multiple bits accepted on the same edge all pulse together and are OR-ed into event_mask.
- The handshake has no backpressure on the input path. Debouncing continues regardless of ack. Repeated changes of one bit before an ack collapse into a single set mask bit.

## Test plan
- Reset/init: INIT_VALUE=2'b10, hold reset low, drive in=2'b01, release reset. Required: out=2'b10, rise=fall=0, event_valid=0 at release; out becomes 2'b01 after STABLE_CYCLES samples, with rise=2'b01 and fall=2'b10 for one cycle.
- Threshold: STABLE_CYCLES=4, WIDTH=1.
  - 3-cycle high pulse on in → out stays 0, no rise, event_valid stays 0.
  - 4-cycle high → out=1 on the 4th sampling edge, rise=1 for one cycle, event_mask=1, event_valid=1.
- Bounce: in toggles 1,0,1,1,0,1,1,1,1 with STABLE_CYCLES=4 → out rises once, only after the final four 1s; exactly one rise pulse.
- Handshake race: bit0 pending in event_mask; bit1 accepted on the same edge event_ack=1 → event_mask becomes 2'b10 and event_valid stays 1. A second ack clears it to 0.
- Mid-operation reset: during a count of 3/4 toward a change, pulse reset low for a partial cycle → outputs return to reset values immediately (asynchronously). The change then needs a full 4 fresh samples after release.
- Multi-bit and STABLE_CYCLES=1: WIDTH=4, in 4'h0→4'hA → next edge out=4'hA, rise=4'hA, fall=0. Then in→4'h5 → out=4'h5, rise=4'h5, fall=4'hA, and event_mask accumulates to 4'hF without ack.
